// File: rtl/stim_sequencer.sv
// Stimulus sequencer: drives an alternating bit into a registered child datapath,
// captures its 2-bit response LATENCY edges later, scores it and keeps a readable log.
module stim_sequencer #(
    parameter int NUM_CYCLES = 10,
    parameter int LATENCY    = 1,
    parameter int AW         = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1,
    parameter int EW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dut_a,
    input  logic [1:0]    dut_b,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data,
    output logic [EW-1:0] err_count,
    output logic [1:0]    test_s
);
    localparam int              WW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(NUM_CYCLES - 1);
    localparam logic [WW-1:0]   WAIT_INIT = WW'(LATENCY - 1);
    localparam logic [AW:0]     NUM_EXT   = (AW + 1)'(NUM_CYCLES);

    if (LATENCY < 1) begin : g_bad_latency
        $error("stim_sequencer: LATENCY must be at least 1");
    end
    if (NUM_CYCLES < 1) begin : g_bad_num_cycles
        $error("stim_sequencer: NUM_CYCLES must be at least 1");
    end

    // state   | meaning
    // IDLE    | waiting for start
    // DRIVE   | present idx[0] on dut_a, arm the latency counter
    // WAIT    | let the child pipeline settle
    // CAPTURE | log and score dut_b, advance idx
    // DONE    | one-cycle end-of-run pulse
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CAPTURE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          a_q, a_d;
    logic [EW-1:0] err_q, err_d;
    logic [1:0]    ts_q, ts_d;
    logic [1:0]    rd_q, rd_d;
    logic          cap_en;
    logic [1:0]    result_q [NUM_CYCLES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_DRIVE;
            S_DRIVE:   state_d = S_WAIT;
            S_WAIT:    if (wcnt_q == '0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        idx_d  = idx_q;
        wcnt_d = wcnt_q;
        a_d    = a_q;
        err_d  = err_q;
        ts_d   = ts_q;
        cap_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    err_d = '0;
                end
            end
            S_DRIVE: begin
                a_d    = idx_q[0];
                wcnt_d = WAIT_INIT;
            end
            S_WAIT: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
            end
            S_CAPTURE: begin
                cap_en = 1'b1;
                if ((dut_b != {a_q, ~a_q}) && (err_q != '1)) err_d = err_q + 1'b1;
                ts_d = {idx_q[0], ~idx_q[0]};
                if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Out-of-range addresses read as zero rather than aliasing into the buffer.
    always_comb begin
        rd_d = 2'b00;
        if ({1'b0, rd_addr} < NUM_EXT) rd_d = result_q[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            wcnt_q <= '0;
            a_q    <= 1'b0;
            err_q  <= '0;
            ts_q   <= 2'b00;
            rd_q   <= 2'b00;
            for (int i = 0; i < NUM_CYCLES; i++) result_q[i] <= 2'b00;
        end else begin
            idx_q  <= idx_d;
            wcnt_q <= wcnt_d;
            a_q    <= a_d;
            err_q  <= err_d;
            ts_q   <= ts_d;
            rd_q   <= rd_d;
            if (cap_en) result_q[idx_q] <= dut_b;
        end
    end

    assign dut_a     = a_q;
    assign err_count = err_q;
    assign test_s    = ts_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: a cycle-indexed model checks the default instance every
// cycle; literal expectations pin timing, saturation and latency variants.
module tb_stim_sequencer;
    localparam int N = 10;
    localparam int L = 1;
    localparam int P = L + 2;
    localparam int T = N * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_l = 1'b0;
    logic       fault = 1'b0;
    logic [3:0] rd_addr = 4'd0;

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic       busy0, done0, a0;
    logic [1:0] rd0, ts0, c0_b, b0;
    logic [7:0] err0;
    logic       busy1, done1, a1;
    logic [1:0] rd1, ts1;
    logic [2:0] err1;
    logic       busy2, done2, a2, c2_s1, c2_s2;
    logic [1:0] rd2, ts2, c2_b;
    logic [7:0] err2;
    logic       busy3, done3, a3, c3_s1, c3_s2;
    logic [1:0] rd3, ts3, c3_b;
    logic [7:0] err3;

    // Child models: one-stage ideal block, and two three-stage pipelines.
    always @(posedge clk or posedge rst)
        if (rst) c0_b <= 2'b00; else c0_b <= {a0, ~a0};
    assign b0 = fault ? 2'b00 : c0_b;

    always @(posedge clk or posedge rst)
        if (rst) begin c2_s1 <= 0; c2_s2 <= 0; c2_b <= 2'b00; end
        else begin c2_s1 <= a2; c2_s2 <= c2_s1; c2_b <= {c2_s2, ~c2_s2}; end

    always @(posedge clk or posedge rst)
        if (rst) begin c3_s1 <= 0; c3_s2 <= 0; c3_b <= 2'b00; end
        else begin c3_s1 <= a3; c3_s2 <= c3_s1; c3_b <= {c3_s2, ~c3_s2}; end

    stim_sequencer u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .dut_a(a0),
        .dut_b(b0), .rd_addr(rd_addr), .rd_data(rd0), .err_count(err0), .test_s(ts0));

    stim_sequencer #(.EW(3)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .dut_a(a1),
        .dut_b(2'b00), .rd_addr(rd_addr), .rd_data(rd1), .err_count(err1), .test_s(ts1));

    stim_sequencer #(.LATENCY(3)) u2 (
        .clk(clk), .rst(rst), .start(start_l), .busy(busy2), .done(done2), .dut_a(a2),
        .dut_b(c2_b), .rd_addr(rd_addr), .rd_data(rd2), .err_count(err2), .test_s(ts2));

    stim_sequencer #(.LATENCY(1)) u3 (
        .clk(clk), .rst(rst), .start(start_l), .busy(busy3), .done(done3), .dut_a(a3),
        .dut_b(c3_b), .rd_addr(rd_addr), .rd_data(rd3), .err_count(err3), .test_s(ts3));

    // Model of u0: k counts edges since start acceptance; iteration i drives at
    // k = 1 + i*P and captures at k = (i+1)*P; done when k == T.
    logic       m_run;
    int         m_k, m_err, ci;
    logic       m_a;
    logic [1:0] m_ts, m_rd, bexp, bgot;
    logic [1:0] m_res [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_k = 0; m_err = 0; m_a = 0; m_ts = 0; m_rd = 0;
            for (int j = 0; j < 16; j++) m_res[j] = 2'b00;
        end else begin
            m_rd = (rd_addr < N) ? m_res[rd_addr] : 2'b00;
            if (!m_run) begin
                if (start) begin m_run = 1; m_k = 0; m_err = 0; end
            end else begin
                m_k = m_k + 1;
                if (m_k > T) m_run = 0;
                else begin
                    if ((m_k - 1) % P == 0) m_a = (((m_k - 1) / P) % 2) == 1;
                    if (m_k % P == 0) begin
                        ci = m_k / P - 1;
                        bexp = {ci[0], ~ci[0]};
                        bgot = fault ? 2'b00 : bexp;
                        m_res[ci] = bgot;
                        if (bgot != bexp && m_err < 255) m_err++;
                        m_ts = bexp;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy0, m_run && m_k < T);
            check("done", done0, m_run && m_k == T);
            check("dut_a", a0, m_a);
            check("test_s", ts0, m_ts);
            check("err_count", err0, m_err);
            check("rd_data", rd0, m_rd);
        end
    end

    task automatic pulse_start(input bit lat, output int t);
        @(posedge clk); #1;
        t = ecnt;
        if (lat) start_l = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_l = 1'b0;
    endtask

    task automatic wait_done(input bit lat, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((lat ? done2 : done0) === 1'b1) begin at = ecnt; break; end
        end
    endtask

    task automatic goto_edge(input int e);
        while (ecnt < e) begin @(posedge clk); #1; end
    endtask

    task automatic sweep(input bit zero);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            @(posedge clk); #1;
            check("readback", rd0, (zero || a >= N) ? 0 : ((a % 2 == 1) ? 2 : 1));
        end
        rd_addr = 4'd0;
    endtask

    int t, at, n;

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_dut_a", a0, 0);
        check("rst_err", err0, 0);
        check("rst_test_s", ts0, 0);
        check("rst_rd_data", rd0, 0);

        // nominal run
        pulse_start(0, t);
        wait_done(0, at);
        check("nom_done_time", at, t + 31);
        check("nom_err", err0, 0);
        check("nom_test_s", ts0, 2'b10);
        sweep(0);

        // start while busy
        pulse_start(0, t);
        goto_edge(t + 5);  start = 1'b1; @(posedge clk); #1; start = 1'b0;
        goto_edge(t + 20); start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_done(0, at);
        check("busy_start_done_time", at, t + 31);
        check("busy_start_err", err0, 0);
        n = 0;
        repeat (12) @(negedge clk) if (done0) n++;
        check("busy_start_extra_done", n, 0);

        // fault injection, plus saturating counter on the EW=3 instance
        fault = 1'b1;
        pulse_start(0, t);
        wait_done(0, at);
        check("fault_done_time", at, t + 31);
        check("fault_err", err0, 10);
        check("fault_err_sat", err1, 7);
        fault = 1'b0;
        sweep(1);

        // reset mid-run, in the WAIT of the fourth iteration
        rd_addr = 4'd1;
        fault = 1'b1;
        pulse_start(0, t);
        goto_edge(t + 4);
        fault = 1'b0;
        goto_edge(t + 11);
        check("pre_rst_busy", busy0, 1);
        check("pre_rst_dut_a", a0, 1);
        check("pre_rst_err", err0, 1);
        check("pre_rst_test_s", ts0, 2'b01);
        check("pre_rst_rd_data", rd0, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_done", done0, 0);
        check("mid_rst_dut_a", a0, 0);
        check("mid_rst_err", err0, 0);
        check("mid_rst_test_s", ts0, 0);
        check("mid_rst_rd_data", rd0, 0);
        #12 rst = 1'b0;
        sweep(1);
        pulse_start(0, t);
        wait_done(0, at);
        check("post_rst_done_time", at, t + 31);
        check("post_rst_err", err0, 0);
        check("post_rst_test_s", ts0, 2'b10);
        sweep(0);

        // latency parameter: matched 3-stage child vs mismatched LATENCY=1
        pulse_start(1, t);
        wait_done(1, at);
        check("lat3_done_time", at, t + 51);
        check("lat3_err", err2, 0);
        pulse_start(1, t);
        wait_done(1, at);
        check("lat3_done_time_2", at, t + 51);
        check("lat3_err_2", err2, 0);
        check("lat1_err", err3, 10);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
